// File: rtl/gravity_drop_pkg.sv
// Shared types and helpers for the gravity drop controller.
package gravity_drop_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    AIRBORNE = 2'd1,
    LANDED   = 2'd2
  } drop_state_e;

  localparam int unsigned FRAC_DEF = 8;

  // Unsigned saturating clamp to an upper bound.
  function automatic logic [31:0] clamp_u(input logic [31:0] value, input logic [31:0] max);
    return (value > max) ? max : value;
  endfunction

endpackage

// File: rtl/gravity_drop_ctl_tick_gen.sv
// Periodic physics tick: registered pulse once every DIV enabled cycles.
module tick_gen #(
  parameter int unsigned DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (DIV > 2) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  // Pulse is issued one count early so the registered tick lands exactly DIV cycles after enable.
  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= (cnt == CW'(DIV - 1)) ? '0 : cnt + CW'(1);
      tick <= (cnt == CW'(DIV - 2));
    end
  end

endmodule

// File: rtl/gravity_drop_ctl.sv
// Click-launched sprite drop: fixed-point gravity integration, damped floor bounces, then rest.
module gravity_drop_ctl
  import gravity_drop_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 100_000_000,
  parameter int unsigned TICK_HZ      = 1000,
  parameter int unsigned H_RES        = 800,
  parameter int unsigned V_RES        = 600,
  parameter int unsigned PIC_WIDTH    = 64,
  parameter int unsigned PIC_HEIGHT   = 64,
  parameter int unsigned XY_W         = 12,
  parameter int unsigned FRAC         = FRAC_DEF,
  parameter int unsigned VW           = 20,
  parameter int unsigned GRAV         = 15,
  parameter int unsigned MAX_BOUNCES  = 2,
  parameter int unsigned DAMP_SHIFT   = 2,
  parameter int unsigned MIN_BOUNCE_V = 64,
  localparam int unsigned BW = (MAX_BOUNCES > 0) ? $clog2(MAX_BOUNCES + 1) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mouse_left,
  input  logic [XY_W-1:0] mouse_xpos,
  input  logic [XY_W-1:0] mouse_ypos,
  output logic [XY_W-1:0] xpos,
  output logic [XY_W-1:0] ypos,
  output logic [1:0]      state,
  output logic [BW-1:0]   bounce_cnt,
  output logic            landed
);

  localparam int unsigned TICK_DIV = CLK_FREQ / TICK_HZ;
  localparam int unsigned FLOOR    = V_RES - PIC_HEIGHT;
  localparam int unsigned XMAX     = H_RES - PIC_WIDTH;
  localparam int unsigned YW       = XY_W + FRAC + 1;
  localparam int unsigned YX       = YW + 1;
  localparam int unsigned VX       = VW + 1;

  localparam logic signed [YX-1:0] FLOOR_FX = YX'(FLOOR << FRAC);
  localparam logic signed [VX-1:0] VSAT_P   = {2'b00, {(VW - 1){1'b1}}};
  localparam logic signed [VX-1:0] VSAT_N   = -VSAT_P;
  localparam logic signed [VX-1:0] GRAV_W   = VX'(GRAV);
  localparam logic signed [VW-1:0] MIN_V    = VW'(MIN_BOUNCE_V);

  drop_state_e            state_q, state_d;
  logic                   mouse_left_q;
  logic signed [YW-1:0]   y_fx, yfx_d;
  logic signed [VW-1:0]   vy, vy_d;
  logic [XY_W-1:0]        xpos_d, ypos_d;
  logic [BW-1:0]          bcnt_d;
  logic                   landed_d;

  logic                   click_c;
  logic                   tick_en_c;
  logic                   tick;
  logic [XY_W-1:0]        x_clamp_c, y_clamp_c;
  logic signed [VX-1:0]   vy_sum;
  logic signed [VW-1:0]   vy_new, rebound;
  logic signed [YX-1:0]   y_sum;

  assign click_c   = mouse_left & ~mouse_left_q;
  assign tick_en_c = (state_q == AIRBORNE) && !click_c;
  assign x_clamp_c = XY_W'(clamp_u(32'(mouse_xpos), XMAX));
  assign y_clamp_c = XY_W'(clamp_u(32'(mouse_ypos), FLOOR));
  assign state     = state_q;

  tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (tick_en_c),
    .tick  (tick)
  );

  // Next-state, integrator and output-register inputs; a click overrides everything else.
  always_comb begin
    state_d  = state_q;
    xpos_d   = xpos;
    ypos_d   = ypos;
    yfx_d    = y_fx;
    vy_d     = vy;
    bcnt_d   = bounce_cnt;
    landed_d = 1'b0;

    vy_sum = VX'(vy) + GRAV_W;
    if (vy_sum > VSAT_P)      vy_new = VW'(VSAT_P);
    else if (vy_sum < VSAT_N) vy_new = VW'(VSAT_N);
    else                      vy_new = VW'(vy_sum);
    y_sum   = YX'(y_fx) + YX'(vy_new);
    rebound = vy_new - (vy_new >>> DAMP_SHIFT);

    case (state_q)
      IDLE: begin
        xpos_d = x_clamp_c;
        ypos_d = y_clamp_c;
      end
      AIRBORNE: begin
        if (tick) begin
          // Floor test uses the untruncated sum so a fast impact cannot wrap past it.
          if (y_sum >= FLOOR_FX) begin
            yfx_d  = YW'(FLOOR_FX);
            ypos_d = XY_W'(FLOOR);
            if ((32'(bounce_cnt) + 32'd1 <= MAX_BOUNCES) && (vy_new >= MIN_V)) begin
              vy_d   = -rebound;
              bcnt_d = bounce_cnt + BW'(1);
            end else begin
              vy_d     = '0;
              state_d  = LANDED;
              landed_d = 1'b1;
            end
          end else if (y_sum < 0) begin
            yfx_d  = '0;
            vy_d   = '0;
            ypos_d = '0;
          end else begin
            yfx_d  = YW'(y_sum);
            vy_d   = vy_new;
            ypos_d = y_sum[FRAC +: XY_W];
          end
        end
      end
      LANDED: ;
      default: state_d = IDLE;
    endcase

    if (click_c) begin
      xpos_d   = x_clamp_c;
      ypos_d   = y_clamp_c;
      yfx_d    = $signed({1'b0, y_clamp_c, {FRAC{1'b0}}});
      vy_d     = '0;
      bcnt_d   = '0;
      landed_d = 1'b0;
      if (32'(mouse_ypos) >= FLOOR) begin
        state_d  = LANDED;
        landed_d = 1'b1;
      end else begin
        state_d = AIRBORNE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mouse_left_q <= 1'b0;
      xpos         <= '0;
      ypos         <= '0;
      y_fx         <= '0;
      vy           <= '0;
      bounce_cnt   <= '0;
      landed       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mouse_left_q <= mouse_left;
      xpos         <= xpos_d;
      ypos         <= ypos_d;
      y_fx         <= yfx_d;
      vy           <= vy_d;
      bounce_cnt   <= bcnt_d;
      landed       <= landed_d;
    end
  end

endmodule
